// File: rtl/fphub_pkg.sv
// Shared state encoding, digit codes and constant builders for the HUB square-root output stage.
package fphub_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, FINAL, DONE} state_t;

    localparam logic [1:0] DIGIT_POS  = 2'b01;
    localparam logic [1:0] DIGIT_ZERO = 2'b00;
    localparam logic [1:0] DIGIT_NEG  = 2'b11;

    function automatic logic [63:0] exp_all_ones(input int e);
        return (64'd1 << e) - 64'd1;
    endfunction

    // Quiet NaN: positive sign, all-ones exponent, only the mantissa MSB set.
    function automatic logic [63:0] qnan_word(input int m, input int e);
        return (exp_all_ones(e) << m) | (64'd1 << (m - 1));
    endfunction

endpackage

// File: rtl/fphub_otf_conv.sv
// On-the-fly conversion of the signed-digit root stream into Q and QM = Q - ulp.
module fphub_otf_conv
    import fphub_pkg::*;
#(
    parameter int N  = 26,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          clr,
    input  logic          digit_vld,
    input  logic [1:0]    digit,
    output logic [N-1:0]  q,
    output logic [N-1:0]  qm,
    output logic [CW-1:0] cnt
);

    localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0] w;

    assign w = MSB >> cnt;

    always_ff @(posedge clk) begin
        if (!rst_l || clr) begin
            q   <= '0;
            qm  <= '0;
            cnt <= '0;
        end else if (digit_vld) begin
            case (digit)
                DIGIT_POS: begin
                    q  <= q | w;
                    qm <= q;
                end
                DIGIT_NEG:         q  <= qm | w;
                DIGIT_ZERO, 2'b10: qm <= qm | w;
            endcase
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fphub_sqrt_pack.sv
// Output stage of the HUB radix-2 square root: classification, exponent halving, result packing.
// Defining FPHUB_SQRT_FLAGS_EN adds a {invalid, zero} flags port; res is unaffected.
module fphub_sqrt_pack
    import fphub_pkg::*;
#(
    parameter int M = 23,
    parameter int E = 8,
    parameter int N = 26
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         start,
    input  logic [M+E:0] x,
    output logic         idle,
    input  logic         digit_vld,
    input  logic [1:0]   digit,
    input  logic         rem_neg,
    output logic [M+E:0] res,
    output logic         res_vld,
    input  logic         res_rdy
`ifdef FPHUB_SQRT_FLAGS_EN
    ,
    output logic [1:0]   flags
`endif
);

    localparam int CW  = $clog2(N + 1);
    localparam int EW1 = E + 1;
    localparam int W   = M + E + 1;
    localparam logic [E-1:0] EXP_ONES = E'(exp_all_ones(E));
    localparam logic [E:0]   BIAS     = EW1'(exp_all_ones(E - 1));
    localparam logic [M+E:0] QNAN     = W'(qnan_word(M, E));

    state_t          state, state_nx;
    logic            x_sign;
    logic [E-1:0]    x_exp;
    logic            is_zero, is_special;
    logic [M+E:0]    special_res;
    logic [E:0]      exp_sum;
    logic [E-1:0]    res_exp;
    logic            rem_neg_q;
    logic            dig_take, last_digit;
    logic [N-1:0]    q, qm, root;
    logic [CW-1:0]   cnt;
    logic [M-1:0]    mant;
    logic            unused_root_bits;

    assign x_sign      = x[M+E];
    assign x_exp       = x[M+E-1:M];
    assign is_zero     = (x_exp == '0);
    assign is_special  = is_zero || x_sign || (x_exp == EXP_ONES);
    assign special_res = is_zero ? {x_sign, {(M+E){1'b0}}} : (x_sign ? QNAN : x);
    assign exp_sum     = {1'b0, x_exp} + BIAS;

    assign idle       = (state == IDLE);
    assign dig_take   = digit_vld && (state == COLLECT);
    assign last_digit = (cnt == CW'(N - 1));

    // The root sits in [1,2): the integer bit is implicit and bits below the HUB mantissa are dropped.
    assign root             = rem_neg_q ? qm : q;
    assign mant             = root[N-2 -: M];
    assign unused_root_bits = ^{root[N-1], root[N-M-2:0]};

    fphub_otf_conv #(.N(N), .CW(CW)) u_otf (
        .clk       (clk),
        .rst_l     (rst_l),
        .clr       (idle),
        .digit_vld (dig_take),
        .digit     (digit),
        .q         (q),
        .qm        (qm),
        .cnt       (cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = is_special ? DONE : COLLECT;
            COLLECT: if (dig_take && last_digit) state_nx = FINAL;
            FINAL:   state_nx = DONE;
            DONE:    if (res_vld && res_rdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            res       <= '0;
            res_vld   <= 1'b0;
            res_exp   <= '0;
            rem_neg_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (is_special) begin
                        res     <= special_res;
                        res_vld <= 1'b1;
                    end else begin
                        res_exp <= exp_sum[E:1];
                    end
                end
                COLLECT: if (dig_take && last_digit) rem_neg_q <= rem_neg;
                FINAL: begin
                    res     <= {1'b0, res_exp, mant};
                    res_vld <= 1'b1;
                end
                DONE: if (res_rdy) res_vld <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef FPHUB_SQRT_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_l)              flags <= 2'b00;
        else if (idle && start)  flags <= {!is_zero && x_sign, is_zero};
    end
`else
    // Flags port and its register are absent in this build.
`endif

    illegal_digit_a: assert property (@(posedge clk) disable iff (!rst_l)
        dig_take |-> (digit != 2'b10));

endmodule

// File: tb/tb_fphub_sqrt_pack.sv
// Bench for fphub_sqrt_pack: directed corner cases plus random operands checked against
// a value-level model (signed-digit sum, halved exponent, special-case table).
module tb_fphub_sqrt_pack;

    localparam int M = 23;
    localparam int E = 8;
    localparam int N = 26;

    logic        clk = 1'b0;
    logic        rst_l, start, idle, digit_vld, rem_neg, res_vld, res_rdy;
    logic [31:0] x, res;
    logic [1:0]  digit;
`ifdef FPHUB_SQRT_FLAGS_EN
    logic [1:0]  flags;
`endif

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [1:0] dig_seq [N];

    always #5 clk = ~clk;

    fphub_sqrt_pack #(.M(M), .E(E), .N(N)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .start     (start),
        .x         (x),
        .idle      (idle),
        .digit_vld (digit_vld),
        .digit     (digit),
        .rem_neg   (rem_neg),
        .res       (res),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy)
`ifdef FPHUB_SQRT_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total_cnt++;
        assert (obs === want) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, obs, want);
        end
    endtask

    function automatic logic [1:0] enc(input int d);
        if (d > 0) return 2'b01;
        if (d < 0) return 2'b11;
        return 2'b00;
    endfunction

    function automatic longint dval(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    // Root value = sum of digit * weight; a negative remainder means the root is one ulp smaller.
    function automatic logic [31:0] model_res(input logic [31:0] xv, input logic rn);
        logic [7:0] e;
        longint v, r, mnt;
        int re;
        e = xv[30:23];
        if (e == 8'h00) return {xv[31], 31'b0};
        if (xv[31])     return 32'h7FC00000;
        if (e == 8'hFF) return xv;
        re = (int'(e) + 127) / 2;
        v = 0;
        for (int i = 0; i < N; i++) v += dval(dig_seq[i]) * (longint'(1) << (N - 1 - i));
        r = v - longint'(rn);
        mnt = (r >> (N - 1 - M)) % (longint'(1) << M);
        return {1'b0, re[7:0], mnt[22:0]};
    endfunction

    function automatic logic [1:0] model_flags(input logic [31:0] xv);
        return {xv[31] && (xv[30:23] != 8'h00), xv[30:23] == 8'h00};
    endfunction

    task automatic set_unit_digits(input int second);
        dig_seq[0] = 2'b01;
        dig_seq[1] = enc(second);
        for (int i = 2; i < N; i++) dig_seq[i] = 2'b00;
    endtask

    // Start one operation and feed dig_seq unless the special path answered at once.
    // lat counts clock edges from the start edge (edge 1) to the edge that raises res_vld.
    task automatic apply_stimulus(input logic [31:0] xv, input logic rn, input int gap_max,
                                  output int lat);
        x     = xv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        if (!res_vld) begin
            for (int i = 0; i < N; i++) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    digit_vld = 1'b0;
                    rem_neg   = ~rn;
                    tick();
                    lat++;
                end
                digit_vld = 1'b1;
                digit     = dig_seq[i];
                rem_neg   = (i == N - 1) ? rn : ~rn;
                tick();
                lat++;
            end
            digit_vld = 1'b0;
            rem_neg   = ~rn;
            for (int k = 0; k < 10 && !res_vld; k++) begin
                tick();
                lat++;
            end
        end
        check_output("res_vld_rise", 32'(res_vld), 32'd1);
    endtask

    // Hold res_rdy low for hold cycles (optionally with ignored start/digit traffic), then accept.
    task automatic consume(input int hold, input logic noisy);
        logic [31:0] held;
        held = res;
        for (int k = 0; k < hold; k++) begin
            res_rdy   = 1'b0;
            start     = noisy;
            x         = 32'h3F800000;
            digit_vld = noisy;
            digit     = 2'b01;
            tick();
            check_output("hold_res", res, held);
            check_output("hold_vld", 32'(res_vld), 32'd1);
        end
        start     = 1'b0;
        digit_vld = 1'b0;
        res_rdy   = 1'b1;
        tick();
        res_rdy = 1'b0;
        check_output("accept_vld_low", 32'(res_vld), 32'd0);
        check_output("accept_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] xv, want;
        logic rn;

        rst_l = 1'b0; start = 1'b0; x = '0; digit_vld = 1'b0; digit = 2'b00;
        rem_neg = 1'b0; res_rdy = 1'b0;
        repeat (3) tick();
        check_output("reset_idle", 32'(idle), 32'd1);
        check_output("reset_vld", 32'(res_vld), 32'd0);
        check_output("reset_res", res, 32'h0);
        rst_l = 1'b1;
        tick();

        set_unit_digits(0);
        apply_stimulus(32'h3F800000, 1'b0, 0, lat);
        check_output("one_lat", 32'(lat), 32'(N + 2));
        check_output("one_res", res, 32'h3F800000);
        consume(2, 1'b0);

        apply_stimulus(32'h40800000, 1'b0, 0, lat);
        check_output("four_res", res, 32'h40000000);
        consume(1, 1'b1);

        set_unit_digits(1);
        apply_stimulus(32'h40800000, 1'b1, 0, lat);
        check_output("four_qm_res", res, 32'h403FFFFF);
        consume(5, 1'b1);

        apply_stimulus(32'hC0800000, 1'b0, 0, lat);
        check_output("neg_lat", 32'(lat), 32'd1);
        check_output("neg_res", res, 32'h7FC00000);
`ifdef FPHUB_SQRT_FLAGS_EN
        check_output("neg_flags", 32'(flags), 32'd2);
`endif
        consume(3, 1'b1);
        digit_vld = 1'b1;
        digit     = 2'b01;
        repeat (2) tick();
        digit_vld = 1'b0;
        check_output("idle_digit_ignored", 32'(idle), 32'd1);
        check_output("idle_digit_vld", 32'(res_vld), 32'd0);

        apply_stimulus(32'h00000000, 1'b0, 0, lat);
        check_output("pzero_res", res, 32'h00000000);
`ifdef FPHUB_SQRT_FLAGS_EN
        check_output("pzero_flags", 32'(flags), 32'd1);
`endif
        consume(0, 1'b0);
        apply_stimulus(32'h80000000, 1'b0, 0, lat);
        check_output("nzero_res", res, 32'h80000000);
`ifdef FPHUB_SQRT_FLAGS_EN
        check_output("nzero_flags", 32'(flags), 32'd1);
`endif
        consume(0, 1'b0);

        apply_stimulus(32'h7F800000, 1'b0, 0, lat);
        check_output("pinf_res", res, 32'h7F800000);
        consume(1, 1'b0);
        apply_stimulus(32'h7FC12345, 1'b0, 0, lat);
        check_output("nan_res", res, 32'h7FC12345);
        consume(1, 1'b0);

        set_unit_digits(0);
        x = 32'h3F800000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            digit_vld = 1'b1;
            digit     = dig_seq[i];
            tick();
        end
        digit_vld = 1'b0;
        rst_l     = 1'b0;
        tick();
        check_output("abort_idle", 32'(idle), 32'd1);
        check_output("abort_vld", 32'(res_vld), 32'd0);
        check_output("abort_res", res, 32'h0);
        rst_l = 1'b1;
        tick();
        apply_stimulus(32'h3F800000, 1'b0, 0, lat);
        check_output("restart_lat", 32'(lat), 32'(N + 2));
        check_output("restart_res", res, 32'h3F800000);
        consume(5, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int mode;
            xv   = $urandom;
            mode = int'($urandom_range(9, 0));
            if (mode == 0)      xv[30:23] = 8'h00;
            else if (mode == 1) xv[30:23] = 8'hFF;
            else if (mode == 2) xv[31]    = 1'b1;
            else begin
                xv[31]    = 1'b0;
                xv[30:23] = 8'($urandom_range(254, 1));
            end
            dig_seq[0] = 2'b01;
            dig_seq[1] = 2'b01;
            for (int i = 2; i < N; i++) dig_seq[i] = enc(int'($urandom_range(2, 0)) - 1);
            rn   = 1'($urandom_range(1, 0));
            want = model_res(xv, rn);
            apply_stimulus(xv, rn, 2, lat);
            check_output($sformatf("rand%0d_res", t), res, want);
`ifdef FPHUB_SQRT_FLAGS_EN
            check_output($sformatf("rand%0d_flags", t), 32'(flags), 32'(model_flags(xv)));
`endif
            consume(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
